// File: rtl/cmd_pkg.sv
// cmd_pkg: shared command-word geometry, loader states and CPU opcodes
package cmd_pkg;

    localparam int CMD_SIZE      = 19;
    localparam int CMD_MEM_SIZE  = 32;
    localparam int CMD_ADDR_SIZE = $clog2(CMD_MEM_SIZE);
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_B0,
        S_B1,
        S_B2,
        S_CSUM,
        S_DONE
    } ld_state_t;

    // Opcode lives in the top three bits of a command word, argument below it.
    localparam int OP_SIZE  = 3;
    localparam int ARG_SIZE = CMD_SIZE - OP_SIZE;

    localparam logic [OP_SIZE-1:0] OP_NOP  = 3'd0;
    localparam logic [OP_SIZE-1:0] OP_LOAD = 3'd1;
    localparam logic [OP_SIZE-1:0] OP_STORE = 3'd2;
    localparam logic [OP_SIZE-1:0] OP_ADD  = 3'd3;
    localparam logic [OP_SIZE-1:0] OP_SUB  = 3'd4;
    localparam logic [OP_SIZE-1:0] OP_JMP  = 3'd5;
    localparam logic [OP_SIZE-1:0] OP_JZ   = 3'd6;
    localparam logic [OP_SIZE-1:0] OP_HALT = 3'd7;

    function automatic logic [CMD_SIZE-1:0] mk_cmd(input logic [OP_SIZE-1:0] op,
                                                   input logic [ARG_SIZE-1:0] arg);
        return {op, arg};
    endfunction

endpackage

// File: rtl/cmd_loader.sv
// cmd_loader: framed byte-stream boot loader feeding the cmd_mem write port
module cmd_loader
    import cmd_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [CMD_ADDR_SIZE-1:0] wr_addr,
    output logic [CMD_SIZE-1:0]      wr_data,
    output logic                     cpu_reset,
    output logic                     load_done,
    output logic                     load_err,
    output logic                     busy
);

    localparam logic [CMD_ADDR_SIZE-1:0] IDX_ONE = 1;
    localparam logic [7:0] MAX_WORDS = 8'(CMD_MEM_SIZE);

    ld_state_t r_state;
    ld_state_t w_next;

    logic [7:0]               r_n;
    logic [7:0]               r_acc;
    logic [CMD_SIZE-17:0]     r_b0;
    logic [7:0]               r_b1;
    logic [CMD_ADDR_SIZE-1:0] r_idx;
    logic                     r_wr_en;
    logic [CMD_ADDR_SIZE-1:0] r_wr_addr;
    logic [CMD_SIZE-1:0]      r_wr_data;
    logic                     r_err;
    logic                     r_cpu_rst;

    logic w_xfer;
    logic w_hdr;
    logic w_n_bad;
    logic w_last;
    logic w_csum_ok;

    assign w_xfer    = in_valid && in_ready;
    assign w_hdr     = in_data == HDR_BYTE;
    assign w_n_bad   = in_data == 8'd0 || in_data > MAX_WORDS;
    assign w_last    = 8'(r_idx) + 8'd1 >= r_n;
    assign w_csum_ok = in_data == r_acc;

    // Outputs are forced to their idle values for the whole reset cycle.
    assign in_ready  = !reset && r_state != S_DONE;
    assign wr_en     = !reset && r_wr_en;
    assign wr_addr   = reset ? '0 : r_wr_addr;
    assign wr_data   = reset ? '0 : r_wr_data;
    assign cpu_reset = reset || (r_state != S_DONE && r_cpu_rst);
    assign load_done = !reset && r_state == S_DONE;
    assign load_err  = !reset && r_err;
    assign busy      = !reset && r_state != S_IDLE && r_state != S_DONE;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode: advance only on an accepted byte, except DONE which lasts one cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = (w_xfer && w_hdr) ? S_COUNT : S_IDLE;
            S_COUNT: w_next = w_xfer ? (w_n_bad ? S_IDLE : S_B0) : S_COUNT;
            S_B0:    w_next = w_xfer ? S_B1 : S_B0;
            S_B1:    w_next = w_xfer ? S_B2 : S_B1;
            S_B2:    w_next = w_xfer ? (w_last ? S_CSUM : S_B0) : S_B2;
            S_CSUM:  w_next = w_xfer ? (w_csum_ok ? S_DONE : S_IDLE) : S_CSUM;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: count capture, checksum, word assembly, write strobe and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_n       <= '0;
            r_acc     <= '0;
            r_b0      <= '0;
            r_b1      <= '0;
            r_idx     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
            r_cpu_rst <= 1'b1;
        end else begin
            r_wr_en <= 1'b0;
            if (r_state == S_DONE) r_cpu_rst <= 1'b0;
            if (w_xfer) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_hdr) begin
                            r_err     <= 1'b0;
                            r_cpu_rst <= 1'b1;
                            r_idx     <= '0;
                            r_acc     <= '0;
                        end
                    end
                    S_COUNT: begin
                        if (w_n_bad) r_err <= 1'b1;
                        r_n   <= in_data;
                        r_acc <= in_data;
                    end
                    S_B0: begin
                        r_b0  <= in_data[CMD_SIZE-17:0];
                        r_acc <= r_acc ^ in_data;
                    end
                    S_B1: begin
                        r_b1  <= in_data;
                        r_acc <= r_acc ^ in_data;
                    end
                    S_B2: begin
                        r_acc     <= r_acc ^ in_data;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_idx;
                        r_wr_data <= {r_b0, r_b1, in_data};
                        if (!w_last) r_idx <= r_idx + IDX_ONE;
                    end
                    S_CSUM: begin
                        if (!w_csum_ok) r_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_loader.sv
// tb_cmd_loader: directed scenario tests for the boot loader
module tb_cmd_loader;
    import cmd_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic [7:0]               in_data = 8'h00;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     wr_en;
    logic [CMD_ADDR_SIZE-1:0] wr_addr;
    logic [CMD_SIZE-1:0]      wr_data;
    logic                     cpu_reset;
    logic                     load_done;
    logic                     load_err;
    logic                     busy;

    int total = 0;
    int bad = 0;

    logic [CMD_ADDR_SIZE-1:0] wa[$];
    logic [CMD_SIZE-1:0]      wd[$];
    int done_cnt = 0;
    int rdy_low = 0;

    bq_t f1 = '{8'hA5, 8'h02, 8'h00, 8'h40, 8'h05, 8'h01, 8'h23, 8'h45, 8'h20};
    bq_t f1_bad = '{8'hA5, 8'h02, 8'h00, 8'h40, 8'h05, 8'h01, 8'h23, 8'h45, 8'h21};

    cmd_loader dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end
        if (load_done === 1'b1) done_cnt++;
        if (in_ready === 1'b0 && reset === 1'b0) rdy_low++;
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt = 0;
        rdy_low = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int t = 0;
        in_data = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (t >= 20) begin
            bad++;
            $display("FAIL send_timeout byte=%h in_ready=%b required=1", b, in_ready);
        end
        @(negedge clk);
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input bq_t q, input bit gap);
        for (int i = 0; i < q.size(); i++) send(q[i], gap && i != q.size() - 1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({wr_en, wr_addr, wr_data, load_done, load_err, busy, cpu_reset, in_ready}
            !== {1'b0, 5'd0, 19'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got wr_en=%b addr=%h data=%h done=%b err=%b busy=%b cpu_rst=%b rdy=%b",
                     wr_en, wr_addr, wr_data, load_done, load_err, busy, cpu_reset, in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({in_ready, busy, cpu_reset, load_err} !== 4'b1010) begin
            bad++;
            $display("FAIL after_reset got rdy=%b busy=%b cpu_rst=%b err=%b required 1 0 1 0",
                     in_ready, busy, cpu_reset, load_err);
        end
    endtask

    task automatic test_basic();
        clear_log();
        send(8'hA5, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_count got=%b required=1", busy);
        end
        for (int i = 1; i < f1.size(); i++) send(f1[i], 1'b0);
        total++;
        if ({load_done, cpu_reset, in_ready, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL done_cycle got done=%b cpu_rst=%b rdy=%b busy=%b required 1 0 0 0",
                     load_done, cpu_reset, in_ready, busy);
        end
        idle(3);
        total++;
        if (wa.size() !== 2 || wa[0] !== 5'd0 || wd[0] !== 19'h04005 || wa[1] !== 5'd1 || wd[1] !== 19'h12345) begin
            bad++;
            $display("FAIL basic_writes got n=%0d w0=(%h,%h) w1=(%h,%h) required (0,04005) (1,12345)",
                     wa.size(), wa[0], wd[0], wa[1], wd[1]);
        end
        total++;
        if ({done_cnt == 1, cpu_reset, load_err, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL basic_status got done_cnt=%0d cpu_rst=%b err=%b busy=%b required 1 0 0 0",
                     done_cnt, cpu_reset, load_err, busy);
        end
    endtask

    task automatic test_bad_csum();
        clear_log();
        send_frame(f1_bad, 1'b0);
        idle(3);
        total++;
        if (wa.size() !== 2 || wd[0] !== 19'h04005 || wd[1] !== 19'h12345) begin
            bad++;
            $display("FAIL csum_writes got n=%0d d0=%h d1=%h required 2 04005 12345", wa.size(), wd[0], wd[1]);
        end
        total++;
        if ({load_err, cpu_reset, done_cnt == 0} !== 3'b111) begin
            bad++;
            $display("FAIL csum_status got err=%b cpu_rst=%b done_cnt=%0d required 1 1 0",
                     load_err, cpu_reset, done_cnt);
        end
    endtask

    task automatic test_bad_count();
        bq_t q;
        logic [7:0] cs;
        clear_log();
        send(8'hA5, 1'b0);
        total++;
        if (load_err !== 1'b0) begin
            bad++;
            $display("FAIL hdr_clears_err got=%b required=0", load_err);
        end
        send(8'h00, 1'b0);
        total++;
        if ({load_err, busy} !== 2'b10) begin
            bad++;
            $display("FAIL count_zero got err=%b busy=%b required 1 0", load_err, busy);
        end
        send(8'hA5, 1'b0);
        send(8'h21, 1'b0);
        idle(2);
        total++;
        if ({load_err, busy, wa.size() == 0} !== 3'b101) begin
            bad++;
            $display("FAIL count_33 got err=%b busy=%b writes=%0d required 1 0 0", load_err, busy, wa.size());
        end
        q = '{8'hA5, 8'h20};
        cs = 8'h20;
        for (int i = 0; i < 32; i++) begin
            q.push_back(8'h00);
            q.push_back(8'h00);
            q.push_back(8'(i));
            cs = cs ^ 8'(i);
        end
        q.push_back(cs);
        send_frame(q, 1'b0);
        idle(3);
        total++;
        if (wa.size() !== 32 || done_cnt !== 1 || load_err !== 1'b0 || cpu_reset !== 1'b0) begin
            bad++;
            $display("FAIL full_frame got writes=%0d done_cnt=%0d err=%b cpu_rst=%b required 32 1 0 0",
                     wa.size(), done_cnt, load_err, cpu_reset);
        end
        for (int i = 0; i < 32 && i < wa.size(); i++) begin
            total++;
            if (wa[i] !== 5'(i) || wd[i] !== 19'(i)) begin
                bad++;
                $display("FAIL full_word%0d got (%h,%h) required (%h,%h)", i, wa[i], wd[i], 5'(i), 19'(i));
            end
        end
    endtask

    task automatic test_junk();
        clear_log();
        send(8'h11, 1'b0);
        send(8'hFF, 1'b0);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL junk_busy got=%b required=0", busy);
        end
        send_frame(f1, 1'b0);
        idle(3);
        total++;
        if (wa.size() !== 2 || wd[0] !== 19'h04005 || wd[1] !== 19'h12345 || done_cnt !== 1 || cpu_reset !== 1'b0) begin
            bad++;
            $display("FAIL junk_frame got writes=%0d d0=%h d1=%h done_cnt=%0d cpu_rst=%b",
                     wa.size(), wd[0], wd[1], done_cnt, cpu_reset);
        end
    endtask

    task automatic test_mid_reset();
        clear_log();
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        send(8'h00, 1'b0);
        send(8'h40, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({in_ready, cpu_reset, busy, wr_en} !== 4'b0100) begin
            bad++;
            $display("FAIL mid_reset_cycle got rdy=%b cpu_rst=%b busy=%b wr_en=%b required 0 1 0 0",
                     in_ready, cpu_reset, busy, wr_en);
        end
        reset = 1'b0;
        idle(3);
        total++;
        if ({busy, cpu_reset, in_ready, wa.size() == 0} !== 4'b0111) begin
            bad++;
            $display("FAIL mid_reset_after got busy=%b cpu_rst=%b rdy=%b writes=%0d required 0 1 1 0",
                     busy, cpu_reset, in_ready, wa.size());
        end
        send_frame(f1, 1'b0);
        idle(3);
        total++;
        if (wa.size() !== 2 || wa[1] !== 5'd1 || wd[1] !== 19'h12345 || done_cnt !== 1 || cpu_reset !== 1'b0) begin
            bad++;
            $display("FAIL reload got writes=%0d a1=%h d1=%h done_cnt=%0d cpu_rst=%b",
                     wa.size(), wa[1], wd[1], done_cnt, cpu_reset);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(f1, 1'b1);
        send_frame(f1, 1'b0);
        idle(3);
        total++;
        if (wa.size() !== 4 || wd[0] !== 19'h04005 || wd[1] !== 19'h12345 ||
            wa[2] !== 5'd0 || wd[2] !== 19'h04005 || wa[3] !== 5'd1 || wd[3] !== 19'h12345) begin
            bad++;
            $display("FAIL b2b_writes got n=%0d d0=%h d1=%h a2=%h d2=%h a3=%h d3=%h",
                     wa.size(), wd[0], wd[1], wa[2], wd[2], wa[3], wd[3]);
        end
        total++;
        if (done_cnt !== 2 || rdy_low !== 2 || load_err !== 1'b0 || cpu_reset !== 1'b0) begin
            bad++;
            $display("FAIL b2b_status got done_cnt=%0d rdy_low=%0d err=%b cpu_rst=%b required 2 2 0 0",
                     done_cnt, rdy_low, load_err, cpu_reset);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_bad_csum();
        test_bad_count();
        test_junk();
        test_mid_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmd_loader.md
Name: cmd_loader

Overview:
Boot-time program loader that is the writer side of the CPU command memory.
- Receives a framed byte stream over a valid/ready interface.
- Assembles 19-bit command words and writes them into cmd_mem through a single write port.
- Holds the CPU in reset while loading and releases it only after a frame passes its checksum.
- Sits between a byte source (UART RX or testbench) and the cmd_mem write port / CPU reset input.

Parameters:
CMD_SIZE, 19, command word width in bits (must be 17..24; packed as 3 bytes).
CMD_MEM_SIZE, 32, command memory depth in words.
CMD_ADDR_SIZE, $clog2(CMD_MEM_SIZE), write address width.
HDR_BYTE, 8'hA5, frame start marker.

Ports:
clk  in  1  clock, all logic on posedge.
reset  in  1  synchronous, active-high.
in_data  in  8  stream byte.
in_valid  in  1  in_data is valid this cycle.
in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready.
wr_en  out  1  cmd_mem write strobe, one cycle per word.
wr_addr  out  CMD_ADDR_SIZE  cmd_mem write address.
wr_data  out  CMD_SIZE  command word.
cpu_reset  out  1  reset to the CPU; 1 while no valid program is present.
load_done  out  1  one-cycle pulse on a successful load.
load_err  out  1  sticky error flag; cleared when the next header is accepted.
busy  out  1  high in every state except IDLE and DONE.

Behaviour:
- Reset (clock and reset: clk, synchronous active-high reset):
  - State goes to IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, load_done=0, load_err=0, busy=0, cpu_reset=1, in_ready=0 during the reset cycle.
  - Reset mid-frame discards the frame; no further writes occur.
- Frame format: HDR_BYTE, N, then N×3 payload bytes, then CSUM.
  - Payload is big-endian per word: word = {b0[CMD_SIZE-17:0], b1, b2}; the unused high bits of b0 are ignored.
  - CSUM = XOR of N and all payload bytes. The header is excluded.
- State sequence: IDLE -> COUNT -> B0 -> B1 -> B2 -> (B0 | CSUM) -> DONE -> IDLE.
  - IDLE: in_ready=1. Bytes other than HDR_BYTE are consumed and dropped. On HDR_BYTE: clear load_err, set cpu_reset=1, clear word index and checksum accumulator, go to COUNT.
  - COUNT: if N==0 or N>CMD_MEM_SIZE, set load_err=1 and go to IDLE; otherwise store N, acc=N, go to B0.
  - B0/B1/B2: each accepted byte is XORed into acc.
    - On accepting B2, the next cycle drives wr_en=1, wr_addr=index, wr_data=assembled word (latency 1 cycle after the last byte).
    - The index then increments. Go to B0 if index+1<N, else to CSUM.
  - CSUM: on accept, compare with acc.
    - Match: go to DONE.
    - Mismatch: load_err=1, cpu_reset stays 1, go to IDLE.
    - Words already written stay written.
  - DONE: held for one cycle with in_ready=0 (backpressure). load_done=1 and cpu_reset is driven to 0 in this cycle. Then go to IDLE.
- cpu_reset stays 0 until the next HDR_BYTE is accepted or reset is applied.
- in_ready=1 in IDLE, COUNT, B0, B1, B2 and CSUM. It is 0 in DONE and during reset.
- Gaps in in_valid are allowed anywhere; state holds when there is no transfer.
- Index never wraps: N<=CMD_MEM_SIZE is enforced in COUNT, so the maximum address is CMD_MEM_SIZE-1.
- A write strobe and the next byte acceptance may occur in the same cycle; there is no stall.
- A HDR_BYTE value inside the payload is treated as data, not resync. Recovery from a corrupted frame requires a checksum error or reset.

Decomposition:
- Shared package cmd_pkg holds:
  - CMD_SIZE, CMD_MEM_SIZE, CMD_ADDR_SIZE, HDR_BYTE;
  - the loader state encoding (IDLE, COUNT, B0, B1, B2, CSUM, DONE);
  - the CPU opcode constants, so the bench encoder and the CPU share one definition.
- No sub-module. FSM, word assembler and checksum stay in one module.
- cmd_mem is owned by the top level, which muxes the write port into it.

Test Plan:
1. Send A5 02 00 40 05 01 23 45 20 -> wr(0,0x04005), wr(1,0x12345), then load_done pulse, cpu_reset 1->0, load_err=0.
2. Same frame with CSUM=21 -> both writes occur, load_err=1, no load_done, cpu_reset stays 1.
3. Send A5 00, then A5 21 -> load_err=1 after each count byte, no writes. Then a valid 32-word frame -> writes to addresses 0..31 with no wrap, then load_done.
4. Send 11 FF followed by the frame from test 1 -> the leading bytes are ignored and the result matches test 1.
5. Send A5 02 00 40 and assert reset for one cycle -> no write, state IDLE, cpu_reset=1. Then the frame from test 1 loads correctly.
6. Send the frame from test 1 with in_valid toggling every other cycle and held high into DONE -> identical writes; in_ready=0 for exactly one cycle in DONE and no byte is lost.
